// File: rtl/cpu_accel_pkg.sv
// Shared defaults and the word type for the CPU accelerator-port bridge.
package cpu_accel_pkg;

   localparam int unsigned DATA_WIDTH_DEF  = 16;
   localparam int unsigned ACCEL_COUNT_DEF = 4;
   localparam int unsigned ID_WIDTH_DEF    = 4;
   localparam int unsigned FIFO_DEPTH_DEF  = 4;

   typedef logic [DATA_WIDTH_DEF-1:0] accel_word_t;

endpackage

// File: rtl/cpu_accel_fifo.sv
// Single-clock FIFO; full/empty come from the registered occupancy count only.
module cpu_accel_fifo
   import cpu_accel_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned DEPTH      = FIFO_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] head_data
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  push_ok, pop_ok;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign push_ok   = push & ~full;
   assign pop_ok    = pop & ~empty;
   assign head_data = mem_q[rd_ptr_q];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the cleared count makes stale contents unreachable.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/cpu_accel_bridge.sv
// Routes CPU accelerator-port accesses by id to per-channel TX/RX FIFOs.
// Define CPU_ACCEL_BRIDGE_ERR_EN to add the sticky 'err' output for dropped enables.
module cpu_accel_bridge
   import cpu_accel_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int unsigned ACCEL_COUNT = ACCEL_COUNT_DEF,
   parameter int unsigned ID_WIDTH    = ID_WIDTH_DEF,
   parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [ID_WIDTH-1:0]                     accel_id,
   output logic                                    accel_can_read,
   output logic                                    accel_can_write,
   input  logic                                    accel_read_enable,
   output logic [DATA_WIDTH-1:0]                   accel_read_data,
   input  logic                                    accel_write_enable,
   input  logic [DATA_WIDTH-1:0]                   accel_write_data,
   output logic [ACCEL_COUNT-1:0]                  dev_tx_valid,
   output logic [ACCEL_COUNT-1:0][DATA_WIDTH-1:0]  dev_tx_data,
   input  logic [ACCEL_COUNT-1:0]                  dev_tx_ready,
   input  logic [ACCEL_COUNT-1:0]                  dev_rx_valid,
   input  logic [ACCEL_COUNT-1:0][DATA_WIDTH-1:0]  dev_rx_data,
   output logic [ACCEL_COUNT-1:0]                  dev_rx_ready
`ifdef CPU_ACCEL_BRIDGE_ERR_EN
   ,
   output logic                                    err
`endif
);

   logic [ACCEL_COUNT-1:0]                 sel;
   logic [ACCEL_COUNT-1:0]                 tx_full, tx_empty, rx_full, rx_empty;
   logic [ACCEL_COUNT-1:0]                 tx_push, rx_pop;
   logic [ACCEL_COUNT-1:0][DATA_WIDTH-1:0] rx_head;
   logic                                   sel_rx_empty, sel_tx_full;
   logic [DATA_WIDTH-1:0]                  sel_rx_head;

   // Out-of-range ids select nothing and read back as empty and full.
   always_comb begin
      sel          = '0;
      sel_rx_empty = 1'b1;
      sel_tx_full  = 1'b1;
      sel_rx_head  = '0;
      for (int unsigned i = 0; i < ACCEL_COUNT; i++) begin
         if (32'(accel_id) == i) begin
            sel[i]       = 1'b1;
            sel_rx_empty = rx_empty[i];
            sel_tx_full  = tx_full[i];
            sel_rx_head  = rx_head[i];
         end
      end
   end

   assign accel_can_read  = ~rst & ~sel_rx_empty;
   assign accel_can_write = ~rst & ~sel_tx_full;
   assign accel_read_data = accel_can_read ? sel_rx_head : '0;

   assign tx_push      = sel & {ACCEL_COUNT{accel_write_enable & accel_can_write}};
   assign rx_pop       = sel & {ACCEL_COUNT{accel_read_enable & accel_can_read}};
   assign dev_tx_valid = ~tx_empty;
   assign dev_rx_ready = ~rx_full & {ACCEL_COUNT{~rst}};

   for (genvar g = 0; g < ACCEL_COUNT; g++) begin : g_ch
      cpu_accel_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx (
         .clk       (clk),
         .rst       (rst),
         .push      (tx_push[g]),
         .push_data (accel_write_data),
         .pop       (dev_tx_ready[g]),
         .full      (tx_full[g]),
         .empty     (tx_empty[g]),
         .head_data (dev_tx_data[g])
      );
      cpu_accel_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
         .clk       (clk),
         .rst       (rst),
         .push      (dev_rx_valid[g]),
         .push_data (dev_rx_data[g]),
         .pop       (rx_pop[g]),
         .full      (rx_full[g]),
         .empty     (rx_empty[g]),
         .head_data (rx_head[g])
      );
   end

`ifdef CPU_ACCEL_BRIDGE_ERR_EN
   logic err_q, err_d;

   // Sticky: any enable presented while its permission flag is low.
   always_comb begin
      err_d = err_q
            | (accel_write_enable & ~accel_can_write)
            | (accel_read_enable  & ~accel_can_read);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_cpu_accel_bridge.sv
// Randomized and directed bench for cpu_accel_bridge against a queue-level model.
module tb_cpu_accel_bridge;
   import cpu_accel_pkg::*;

   localparam int NCH   = 4;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        accel_id;
   logic              accel_can_read, accel_can_write;
   logic              accel_read_enable, accel_write_enable;
   logic [15:0]       accel_read_data, accel_write_data;
   logic [3:0]        dev_tx_valid, dev_tx_ready, dev_rx_valid, dev_rx_ready;
   logic [3:0][15:0]  dev_tx_data, dev_rx_data;

   int checks = 0;
   int errors = 0;

   accel_word_t txm [NCH][DEPTH];
   accel_word_t rxm [NCH][DEPTH];
   int          txn [NCH];
   int          rxn [NCH];

   always #5 clk = ~clk;

   cpu_accel_bridge #(.DATA_WIDTH(16), .ACCEL_COUNT(NCH), .ID_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .accel_id           (accel_id),
      .accel_can_read     (accel_can_read),
      .accel_can_write    (accel_can_write),
      .accel_read_enable  (accel_read_enable),
      .accel_read_data    (accel_read_data),
      .accel_write_enable (accel_write_enable),
      .accel_write_data   (accel_write_data),
      .dev_tx_valid       (dev_tx_valid),
      .dev_tx_data        (dev_tx_data),
      .dev_tx_ready       (dev_tx_ready),
      .dev_rx_valid       (dev_rx_valid),
      .dev_rx_data        (dev_rx_data),
      .dev_rx_ready       (dev_rx_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NCH; i++) begin
         txn[i] = 0;
         rxn[i] = 0;
      end
   endtask

   // Expected CPU-side and device-side view from the model queues.
   task automatic model_check();
      int          id;
      logic        exp_cr, exp_cw;
      logic [15:0] exp_rd;
      id     = int'(accel_id);
      exp_cr = 1'b0;
      exp_cw = 1'b0;
      exp_rd = '0;
      if (id < NCH) begin
         exp_cr = (rxn[id] > 0);
         exp_cw = (txn[id] < DEPTH);
         if (exp_cr) exp_rd = rxm[id][0];
      end
      chk("can_read", 32'(accel_can_read), 32'(exp_cr));
      chk("can_write", 32'(accel_can_write), 32'(exp_cw));
      chk("read_data", 32'(accel_read_data), 32'(exp_rd));
      for (int i = 0; i < NCH; i++) begin
         chk($sformatf("tx_valid%0d", i), 32'(dev_tx_valid[i]), 32'(txn[i] > 0));
         if (txn[i] > 0) chk($sformatf("tx_data%0d", i), 32'(dev_tx_data[i]), 32'(txm[i][0]));
         chk($sformatf("rx_ready%0d", i), 32'(dev_rx_ready[i]), 32'(rxn[i] < DEPTH));
      end
   endtask

   // Apply the transfers that the coming edge performs, from pre-edge occupancy.
   task automatic model_update();
      logic tpop, tpush, rpop, rpush;
      for (int i = 0; i < NCH; i++) begin
         tpop  = dev_tx_ready[i] && txn[i] > 0;
         tpush = int'(accel_id) == i && accel_write_enable && txn[i] < DEPTH;
         rpush = dev_rx_valid[i] && rxn[i] < DEPTH;
         rpop  = int'(accel_id) == i && accel_read_enable && rxn[i] > 0;
         if (tpop) begin
            for (int k = 0; k < DEPTH - 1; k++) txm[i][k] = txm[i][k+1];
            txn[i]--;
         end
         if (tpush) begin
            txm[i][txn[i]] = accel_write_data;
            txn[i]++;
         end
         if (rpop) begin
            for (int k = 0; k < DEPTH - 1; k++) rxm[i][k] = rxm[i][k+1];
            rxn[i]--;
         end
         if (rpush) begin
            rxm[i][rxn[i]] = dev_rx_data[i];
            rxn[i]++;
         end
      end
   endtask

   task automatic step(input logic [3:0] id, input logic we, input logic [15:0] wd,
                       input logic re, input logic [3:0] txr, input logic [3:0] rxv,
                       input logic [63:0] rxd);
      @(negedge clk);
      accel_id           = id;
      accel_write_enable = we;
      accel_write_data   = wd;
      accel_read_enable  = re;
      dev_tx_ready       = txr;
      dev_rx_valid       = rxv;
      dev_rx_data        = rxd;
      #1;
      model_check();
      model_update();
   endtask

   task automatic rst_zero_check(input string tag);
      chk({tag, "_can_read"}, 32'(accel_can_read), 32'h0);
      chk({tag, "_can_write"}, 32'(accel_can_write), 32'h0);
      chk({tag, "_read_data"}, 32'(accel_read_data), 32'h0);
      chk({tag, "_tx_valid"}, 32'(dev_tx_valid), 32'h0);
      chk({tag, "_rx_ready"}, 32'(dev_rx_ready), 32'h0);
   endtask

   initial begin
      logic [3:0] txr, rxv;
      logic       phase;

      // Reset with busy inputs: everything toward CPU and devices must be 0.
      rst                = 1'b1;
      accel_id           = 4'd0;
      accel_write_enable = 1'b1;
      accel_write_data   = 16'hFFFF;
      accel_read_enable  = 1'b1;
      dev_tx_ready       = 4'hF;
      dev_rx_valid       = 4'hF;
      dev_rx_data        = {4{16'h1357}};
      clear_model();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         rst_zero_check("reset");
      end
      @(negedge clk);
      rst                = 1'b0;
      accel_write_enable = 1'b0;
      accel_read_enable  = 1'b0;
      dev_rx_valid       = 4'h0;
      #1;
      chk("post_rst_can_write", 32'(accel_can_write), 32'h1);
      chk("post_rst_can_read", 32'(accel_can_read), 32'h0);
      chk("post_rst_rx_ready", 32'(dev_rx_ready), 32'hF);
      chk("post_rst_tx_valid", 32'(dev_tx_valid), 32'h0);

      // TX fill on channel 1 with the device stalled.
      for (int k = 0; k < 4; k++) step(4'd1, 1'b1, 16'h0011 + 16'(k), 1'b0, 4'hD, 4'h0, 64'h0);
      step(4'd1, 1'b1, 16'h0015, 1'b0, 4'hD, 4'h0, 64'h0);
      chk("txfill_can_write", 32'(accel_can_write), 32'h0);
      chk("txfill_head", 32'(dev_tx_data[1]), 32'h0011);
      for (int k = 0; k < 4; k++) begin
         step(4'd1, 1'b0, 16'h0, 1'b0, 4'hF, 4'h0, 64'h0);
         chk("txdrain_valid", 32'(dev_tx_valid[1]), 32'h1);
         chk("txdrain_data", 32'(dev_tx_data[1]), 32'h0011 + 32'(k));
      end
      step(4'd1, 1'b0, 16'h0, 1'b1, 4'hF, 4'h0, 64'h0);
      chk("txdrain_empty", 32'(dev_tx_valid[1]), 32'h0);

      // RX path on channel 2.
      step(4'd2, 1'b0, 16'h0, 1'b0, 4'hF, 4'h4, {16'h0, 16'hBEEF, 16'h0, 16'h0});
      chk("rx_first_can_read", 32'(accel_can_read), 32'h0);
      step(4'd2, 1'b0, 16'h0, 1'b0, 4'hF, 4'h4, {16'h0, 16'h1234, 16'h0, 16'h0});
      chk("rx_can_read", 32'(accel_can_read), 32'h1);
      chk("rx_data0", 32'(accel_read_data), 32'hBEEF);
      step(4'd2, 1'b0, 16'h0, 1'b1, 4'hF, 4'h0, 64'h0);
      step(4'd2, 1'b0, 16'h0, 1'b1, 4'hF, 4'h0, 64'h0);
      chk("rx_data1", 32'(accel_read_data), 32'h1234);
      step(4'd2, 1'b0, 16'h0, 1'b0, 4'hF, 4'h0, 64'h0);
      chk("rx_done_can_read", 32'(accel_can_read), 32'h0);
      chk("rx_done_data", 32'(accel_read_data), 32'h0);

      // Full TX[0]: simultaneous CPU push and device pop; only the pop lands.
      for (int k = 0; k < 4; k++) step(4'd0, 1'b1, 16'h00A0 + 16'(k), 1'b0, 4'hE, 4'h0, 64'h0);
      step(4'd0, 1'b1, 16'h5555, 1'b0, 4'hF, 4'h0, 64'h0);
      chk("full_can_write", 32'(accel_can_write), 32'h0);
      step(4'd0, 1'b0, 16'h0, 1'b0, 4'hE, 4'h0, 64'h0);
      chk("full_after_can_write", 32'(accel_can_write), 32'h1);
      chk("full_after_head", 32'(dev_tx_data[0]), 32'h00A1);
      for (int k = 1; k < 4; k++) begin
         step(4'd0, 1'b0, 16'h0, 1'b0, 4'hF, 4'h0, 64'h0);
         chk("full_drain", 32'(dev_tx_data[0]), 32'h00A0 + 32'(k));
      end
      step(4'd0, 1'b0, 16'h0, 1'b0, 4'hF, 4'h0, 64'h0);
      chk("full_drain_empty", 32'(dev_tx_valid[0]), 32'h0);

      // Out-of-range ids: no permission, no data, no state change.
      step(4'd2, 1'b0, 16'h0, 1'b0, 4'h0, 4'h4, {16'h0, 16'h7777, 16'h0, 16'h0});
      step(4'd4, 1'b1, 16'hAAAA, 1'b1, 4'h0, 4'h0, 64'h0);
      chk("oor4_can_write", 32'(accel_can_write), 32'h0);
      chk("oor4_can_read", 32'(accel_can_read), 32'h0);
      step(4'd15, 1'b1, 16'hAAAA, 1'b1, 4'h0, 4'h0, 64'h0);
      chk("oor15_read_data", 32'(accel_read_data), 32'h0);
      step(4'd2, 1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 64'h0);
      chk("oor_rx_kept", 32'(accel_read_data), 32'h7777);
      step(4'd2, 1'b0, 16'h0, 1'b1, 4'h0, 4'h0, 64'h0);

      // Asynchronous reset between edges with words buffered on channel 3.
      step(4'd3, 1'b1, 16'h0A01, 1'b0, 4'h0, 4'h0, 64'h0);
      step(4'd3, 1'b1, 16'h0A02, 1'b0, 4'h0, 4'h8, {16'h0B01, 16'h0, 16'h0, 16'h0});
      step(4'd3, 1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 64'h0);
      chk("pre_rst_tx_valid", 32'(dev_tx_valid[3]), 32'h1);
      chk("pre_rst_can_read", 32'(accel_can_read), 32'h1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      rst_zero_check("midrst");
      clear_model();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_rel_can_write", 32'(accel_can_write), 32'h1);
      step(4'd3, 1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 64'h0);
      chk("midrst_tx_empty", 32'(dev_tx_valid), 32'h0);
      chk("midrst_rx_empty", 32'(accel_can_read), 32'h0);

      // Random traffic, alternating light and heavy device backpressure.
      phase = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] id;
         if (c % 250 == 0) phase = ~phase;
         id  = ($urandom_range(0, 5) == 5) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         txr = phase ? 4'($urandom) : 4'($urandom & $urandom & $urandom);
         rxv = phase ? 4'($urandom & $urandom & $urandom) : 4'($urandom);
         step(id, 1'($urandom), 16'($urandom), 1'($urandom), txr, rxv,
              {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
